// File: rtl/bist_checkerboard_ctrl_pkg.sv
// Shared types and constants for the checkerboard BIST controller.
// Optional build macro used by this slice: BIST_FAIL_LOG_EN (see bist_rd_checker).
`ifndef SRAM_ADDR_WIDTH
`define SRAM_ADDR_WIDTH 8
`endif

package bist_checkerboard_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = `SRAM_ADDR_WIDTH;
  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_READ_LAT   = 1;

  // Checkerboard words for pattern bit p=0 and p=1; wider words repeat the low pair.
  localparam logic [3:0] PAT_A = 4'b0101;
  localparam logic [3:0] PAT_B = 4'b1010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/bist_checkerboard_ctrl_if.sv
// SRAM port bundle between the BIST controller (master) and the SRAM (slave).
interface bist_checkerboard_ctrl_if
  import bist_checkerboard_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  cs;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output cs, output we, output addr, output wdata, input rdata);
  modport slave  (input cs, input we, input addr, input wdata, output rdata);

endinterface

// File: rtl/bist_rd_checker.sv
// Read-data checker: carries expected word/address alongside each read for
// READ_LAT cycles, compares against returned data and keeps a sticky fail.
// BIST_FAIL_LOG_EN adds first-fail address and saturating mismatch count;
// without it those outputs are constant zero and no log flops exist.
module bist_rd_checker #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 4,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  rd_issue,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_exp,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [7:0]            fail_count
);

  logic [READ_LAT-1:0]   vld_q;
  logic [DATA_WIDTH-1:0] exp_q [READ_LAT];
  logic                  mismatch;

  assign mismatch = vld_q[READ_LAT-1] && (rdata != exp_q[READ_LAT-1]);

  // Valid bits of the compare pipeline; cleared on reset so nothing stale is checked.
  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= (vld_q << 1) | READ_LAT'(rd_issue);
  end

  // Expected-word delay line, aligned with sram_rdata at the last stage.
  always_ff @(posedge clk) begin
    exp_q[0] <= rd_exp;
    for (int i = READ_LAT - 1; i > 0; i--) exp_q[i] <= exp_q[i-1];
  end

  // Sticky fail flag, cleared at the start of each run.
  always_ff @(posedge clk) begin
    if (rst || clr)    fail <= 1'b0;
    else if (mismatch) fail <= 1'b1;
  end

`ifdef BIST_FAIL_LOG_EN
  logic [ADDR_WIDTH-1:0] addr_q [READ_LAT];

  // Address delay line, only needed to log where the first mismatch happened.
  always_ff @(posedge clk) begin
    addr_q[0] <= rd_addr;
    for (int i = READ_LAT - 1; i > 0; i--) addr_q[i] <= addr_q[i-1];
  end

  // First-fail address (fail still low means no earlier mismatch) and saturating count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      fail_addr  <= '0;
      fail_count <= '0;
    end else if (mismatch) begin
      if (!fail) fail_addr <= addr_q[READ_LAT-1];
      if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
    end
  end
`else
  logic unused_rd_addr;

  assign unused_rd_addr = ^rd_addr;
  assign fail_addr      = '0;
  assign fail_count     = '0;
`endif

endmodule

// File: rtl/bist_checkerboard_ctrl.sv
// Checkerboard BIST sequencer for the SRAM: write pattern, verify, write
// inverted pattern, verify, then drain the read pipeline and report.
// Optional macro BIST_FAIL_LOG_EN enables fail_addr/fail_count logging.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | after reset, waiting for start
//   ST_WRITE | one write per cycle, addr 0..max, pattern by pass
//   ST_READ  | one read per cycle, addr 0..max, compared downstream
//   ST_DRAIN | no access, READ_LAT cycles for last compares to land
//   ST_DONE  | done=1, result held until start or rst
module bist_checkerboard_ctrl
  import bist_checkerboard_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int READ_LAT   = DEF_READ_LAT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  bist_checkerboard_ctrl_if.master  sram,
  output logic                      busy,
  output logic                      done,
  output logic                      fail,
  output logic [ADDR_WIDTH-1:0]     fail_addr,
  output logic [7:0]                fail_count
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX   = {ADDR_WIDTH{1'b1}};
  localparam logic [2:0]            DRAIN_INIT = 3'(READ_LAT - 1);
  localparam logic [DATA_WIDTH-1:0] WORD_P0    = {(DATA_WIDTH/2){PAT_A[1:0]}};
  localparam logic [DATA_WIDTH-1:0] WORD_P1    = {(DATA_WIDTH/2){PAT_B[1:0]}};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  pass_q, pass_d;
  logic [2:0]            drain_q, drain_d;
  logic                  clr_run;
  logic [DATA_WIDTH-1:0] pat_word;

  assign pat_word = (addr_q[0] ^ pass_q) ? WORD_P1 : WORD_P0;

  // Everything visible outside is decoded from state/addr/pass registers.
  assign sram.cs    = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign sram.we    = (state_q == ST_WRITE);
  assign sram.addr  = addr_q;
  assign sram.wdata = (state_q == ST_WRITE) ? pat_word : '0;
  assign busy       = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);

  // State, address/pass counter and drain down-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      pass_q  <= 1'b0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pass_q  <= pass_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic; phases chain back-to-back with the address wrapping to 0.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pass_d  = pass_q;
    drain_d = drain_q;
    clr_run = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_WRITE;
          addr_d  = '0;
          pass_d  = 1'b0;
          clr_run = 1'b1;
        end
      end
      ST_WRITE: begin
        if (addr_q == ADDR_MAX) begin
          state_d = ST_READ;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      ST_READ: begin
        if (addr_q == ADDR_MAX) begin
          addr_d = '0;
          if (!pass_q) begin
            state_d = ST_WRITE;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_INIT;
          end
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 3'd0) state_d = ST_DONE;
        else                 drain_d = drain_q - 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  bist_rd_checker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .READ_LAT   (READ_LAT)
  ) u_rd_checker (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr_run),
    .rd_issue   (state_q == ST_READ),
    .rd_addr    (addr_q),
    .rd_exp     (pat_word),
    .rdata      (sram.rdata),
    .fail       (fail),
    .fail_addr  (fail_addr),
    .fail_count (fail_count)
  );

endmodule

// File: tb/tb_bist_checkerboard_ctrl.sv
// Bench for bist_checkerboard_ctrl: two instances (READ_LAT 1 and 3) with
// behavioural SRAMs, fault injection on the first, scoreboard checking.
module tb_bist_checkerboard_ctrl;

  localparam int NOFAIL = 32'h7fff_ffff;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start;
  logic [1:0] busy, done, fail;
  logic [7:0] fail_addr [2];
  logic [7:0] fail_count [2];

  always #5 clk = ~clk;

  bist_checkerboard_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(4)) sif1 ();
  bist_checkerboard_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(4)) sif3 ();

  bist_checkerboard_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(4), .READ_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .start(start[0]), .sram(sif1),
    .busy(busy[0]), .done(done[0]), .fail(fail[0]),
    .fail_addr(fail_addr[0]), .fail_count(fail_count[0])
  );

  bist_checkerboard_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(4), .READ_LAT(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .start(start[1]), .sram(sif3),
    .busy(busy[1]), .done(done[1]), .fail(fail[1]),
    .fail_addr(fail_addr[1]), .fail_count(fail_count[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SRAM models ----------------
  bit stuck_en   = 1'b0;
  bit corrupt_en = 1'b0;

  function automatic logic [3:0] sram_read(input logic [7:0] a, input logic [3:0] v);
    logic [3:0] r;
    r = v;
    if (stuck_en && a == 8'h05) r = r & 4'b1101;
    if (corrupt_en && a == 8'hFF && v == 4'b0101) r = ~r;
    return r;
  endfunction

  logic [3:0] mem0 [256];
  logic [3:0] rd0;
  always @(posedge clk) begin
    if (sif1.cs && sif1.we) mem0[sif1.addr] <= sif1.wdata;
    rd0 <= (sif1.cs && !sif1.we) ? sram_read(sif1.addr, mem0[sif1.addr]) : 4'h0;
  end
  assign sif1.rdata = rd0;

  logic [3:0] mem1 [256];
  logic [3:0] rp1 [3];
  always @(posedge clk) begin
    if (sif3.cs && sif3.we) mem1[sif3.addr] <= sif3.wdata;
    rp1[0] <= (sif3.cs && !sif3.we) ? mem1[sif3.addr] : 4'h0;
    rp1[1] <= rp1[0];
    rp1[2] <= rp1[1];
  end
  assign sif3.rdata = rp1[2];

  // ---------------- scoreboard ----------------
  typedef struct {
    int          d;
    int          cyc;
    logic [63:0] tag;
    logic [32:0] exp;
    bit          wd_care;
  } bus_rec_t;

  typedef struct {
    int          d;
    int          done_cyc;
    int          busy_len;
    logic [16:0] st;
  } run_rec_t;

  bus_rec_t bus_q[$];
  run_rec_t run_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [7:0] logv(input logic [7:0] v);
`ifdef BIST_FAIL_LOG_EN
    return v;
`else
    return v & 8'h00;
`endif
  endfunction

  task automatic push_bus(input int d, input int c, input logic [63:0] tag,
                          input bit cs, input bit we, input logic [7:0] a,
                          input logic [3:0] wd, input bit wdc, input bit b, input bit dn,
                          input int f_from, input logic [7:0] fa, input logic [7:0] fc);
    bus_rec_t r;
    bit f;
    f         = (c >= f_from);
    r.d       = d;
    r.cyc     = c;
    r.tag     = tag;
    r.wd_care = wdc;
    r.exp     = {cs, we, a, wd, b, dn, f, f ? logv(fa) : 8'h00, f ? logv(fc) : 8'h00};
    bus_q.push_back(r);
  endtask

  // Expected SRAM traffic and status at key points of a full run started at T.
  task automatic push_run(input int d, input int T, input int lat, input int f_from,
                          input logic [7:0] fa, input logic [7:0] fc);
    run_rec_t rr;
    push_bus(d, T+1,    "wr0",    1, 1, 8'h00, 4'h5, 1, 1, 0, f_from, fa, fc);
    push_bus(d, T+2,    "wr1",    1, 1, 8'h01, 4'hA, 1, 1, 0, f_from, fa, fc);
    push_bus(d, T+256,  "wrlast", 1, 1, 8'hFF, 4'hA, 1, 1, 0, f_from, fa, fc);
    push_bus(d, T+257,  "rd0",    1, 0, 8'h00, 4'h0, 0, 1, 0, f_from, fa, fc);
    push_bus(d, T+513,  "iwr0",   1, 1, 8'h00, 4'hA, 1, 1, 0, f_from, fa, fc);
    push_bus(d, T+514,  "iwr1",   1, 1, 8'h01, 4'h5, 1, 1, 0, f_from, fa, fc);
    push_bus(d, T+769,  "ird0",   1, 0, 8'h00, 4'h0, 0, 1, 0, f_from, fa, fc);
    push_bus(d, T+1024, "rdlast", 1, 0, 8'hFF, 4'h0, 0, 1, 0, f_from, fa, fc);
    for (int k = 0; k < lat; k++)
      push_bus(d, T+1025+k, "drain", 0, 0, 8'h00, 4'h0, 0, 1, 0, f_from, fa, fc);
    push_bus(d, T+1025+lat, "done",   0, 0, 8'h00, 4'h0, 0, 0, 1, f_from, fa, fc);
    rr.d        = d;
    rr.done_cyc = T + 1025 + lat;
    rr.busy_len = 1024 + lat;
    rr.st       = (f_from != NOFAIL) ? {1'b1, logv(fa), logv(fc)} : 17'h0;
    run_q.push_back(rr);
  endtask

  // Monitor: done-rise and cycle-tagged bus/status checks, sampled on negedge.
  logic [1:0] busy_prev = 2'b00;
  logic [1:0] done_prev = 2'b00;
  int         busy_cnt [2] = '{0, 0};
  run_rec_t   m_rr;
  bus_rec_t   m_br;
  logic [32:0] m_act, m_mask;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (busy[d] && !busy_prev[d]) busy_cnt[d] = 1;
      else if (busy[d])             busy_cnt[d] = busy_cnt[d] + 1;
      if (done[d] && !done_prev[d]) begin
        total++;
        if (run_q.size() == 0 || run_q[0].d != d) begin
          bad++;
          $display("FAIL unexpected_done dut=%0d cyc=%0d got=1 want=no run pending", d, cyc);
        end else begin
          m_rr = run_q.pop_front();
          if (cyc != m_rr.done_cyc) begin
            bad++;
            $display("FAIL done_time dut=%0d got=%0d want=%0d", d, cyc, m_rr.done_cyc);
          end
          total++;
          if (busy_cnt[d] != m_rr.busy_len) begin
            bad++;
            $display("FAIL busy_len dut=%0d got=%0d want=%0d", d, busy_cnt[d], m_rr.busy_len);
          end
          total++;
          if ({fail[d], fail_addr[d], fail_count[d]} != m_rr.st) begin
            bad++;
            $display("FAIL result dut=%0d got=%h want=%h", d,
                     {fail[d], fail_addr[d], fail_count[d]}, m_rr.st);
          end
        end
      end
    end
    busy_prev = busy;
    done_prev = done;
    while (bus_q.size() > 0 && bus_q[0].cyc <= cyc) begin
      m_br   = bus_q.pop_front();
      m_act  = (m_br.d == 0)
             ? {sif1.cs, sif1.we, sif1.addr, sif1.wdata, busy[0], done[0], fail[0], fail_addr[0], fail_count[0]}
             : {sif3.cs, sif3.we, sif3.addr, sif3.wdata, busy[1], done[1], fail[1], fail_addr[1], fail_count[1]};
      m_mask = m_br.wd_care ? {33{1'b1}} : ~(33'h0F << 19);
      total++;
      if (m_br.cyc != cyc || (m_act & m_mask) != (m_br.exp & m_mask)) begin
        bad++;
        $display("FAIL %0s dut=%0d cyc=%0d (due %0d) got=%h want=%h",
                 m_br.tag, m_br.d, cyc, m_br.cyc, m_act & m_mask, m_br.exp & m_mask);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_run(input int d, output int T);
    @(negedge clk);
    T        = cyc;
    start[d] = 1'b1;
  endtask

  task automatic wait_done(input int d, input int T, input bit spam);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      start[d] = spam && (cyc == T+10 || cyc == T+600 || cyc == T+1000);
      if (done[d] && cyc >= T + 2) begin
        got = 1'b1;
        break;
      end
    end
    start[d] = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL done_timeout dut=%0d got=no done want=done within 1200 cycles", d);
    end
  endtask

  int t0;

  initial begin
    rst   = 1'b1;
    start = 2'b00;
    repeat (3) @(negedge clk);
    push_bus(0, 4, "reset", 0, 0, 8'h00, 4'h0, 1, 0, 0, NOFAIL, 8'h00, 8'h00);
    push_bus(1, 4, "reset", 0, 0, 8'h00, 4'h0, 1, 0, 0, NOFAIL, 8'h00, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // good run, READ_LAT=1
    start_run(0, t0);
    push_run(0, t0, 1, NOFAIL, 8'h00, 8'h00);
    wait_done(0, t0, 1'b0);

    // stuck-at-0 on bit 1 at address 5: only the pass-0 read (1010) sees it
    stuck_en = 1'b1;
    start_run(0, t0);
    push_run(0, t0, 1, t0 + 264, 8'h05, 8'h01);
    wait_done(0, t0, 1'b0);

    // restart from DONE clears the result; start spam while busy is ignored
    stuck_en = 1'b0;
    start_run(0, t0);
    push_run(0, t0, 1, NOFAIL, 8'h00, 8'h00);
    wait_done(0, t0, 1'b1);

    // only the very last read is corrupted; fail must coincide with done
    corrupt_en = 1'b1;
    start_run(0, t0);
    push_run(0, t0, 1, t0 + 1026, 8'hFF, 8'h01);
    wait_done(0, t0, 1'b0);

    // reset in the middle of the first read sweep
    corrupt_en = 1'b0;
    start_run(0, t0);
    push_bus(0, t0+300, "midrd", 1, 0, 8'h2B, 4'h0, 0, 1, 0, NOFAIL, 8'h00, 8'h00);
    push_bus(0, t0+301, "rstout", 0, 0, 8'h00, 4'h0, 1, 0, 0, NOFAIL, 8'h00, 8'h00);
    push_bus(0, t0+302, "idle",   0, 0, 8'h00, 4'h0, 1, 0, 0, NOFAIL, 8'h00, 8'h00);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (cyc == t0 + 300) rst = 1'b1;
      if (cyc >= t0 + 301) begin
        rst = 1'b0;
        break;
      end
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // clean run after the aborted one
    start_run(0, t0);
    push_run(0, t0, 1, NOFAIL, 8'h00, 8'h00);
    wait_done(0, t0, 1'b0);

    // READ_LAT=3 instance with a 3-cycle SRAM
    start_run(1, t0);
    push_run(1, t0, 3, NOFAIL, 8'h00, 8'h00);
    wait_done(1, t0, 1'b0);

    repeat (5) @(negedge clk);
    total++;
    if (bus_q.size() != 0) begin
      bad++;
      $display("FAIL bus_q_drained got=%0d want=0", bus_q.size());
    end
    total++;
    if (run_q.size() != 0) begin
      bad++;
      $display("FAIL run_q_drained got=%0d want=0", run_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
